brownout_ctrl: RTL
==================

Name: brownout_ctrl

Overview:
- Digital consumer of the on-chip RC oscillator in the brownout macro. It drives `osc_ena` to start the oscillator when the analog comparator flags under-voltage.
- It synchronises and glitch-filters the comparator output on `osc_ck`, asserts a filtered brownout flag, and holds that flag for a programmable number of oscillator cycles after recovery.
- It then parks with the oscillator stopped, so there is zero dynamic power when idle.
- Nominal `osc_ck` is about 41 MHz (half-period 12195.2 ps).

Parameters:
- FILT_DEPTH, 4, consecutive synchronised high samples of `dcomp` required to trip; legal range 2..15.
- TMR_W, 8, width of the hold-off timer and of `hold_cnt`.
- CNT_W, 8, width of the saturating trip counter.

Ports:
- osc_ck  in  1  oscillator clock; only toggles while `osc_ena`=1, otherwise held 0.
- rst  in  1  asynchronous, active-high reset.
- ena  in  1  block enable; 0 asynchronously clears the FSM, timers and synchroniser (not `brout_cnt`).
- dcomp  in  1  raw comparator output, asynchronous; 1 = supply below threshold.
- hold_cnt  in  TMR_W  hold-off length in `osc_ck` cycles; quasi-static, sampled on entry to HOLD.
- osc_ena  out  1  oscillator enable, combinational.
- brout_filt  out  1  filtered brownout flag, registered.
- busy  out  1  registered; 1 whenever the FSM is not IDLE.
- brout_cnt  out  CNT_W  number of trips since `rst`, saturating.

Behaviour:
- Reset (`rst`=1): state=IDLE, `brout_filt`=0, `busy`=0, `brout_cnt`=0, filter counter=0, timer=0, sync flops=0.
- `ena`=0 gives the same asynchronous clear, except `brout_cnt` is retained.
- Synchroniser: 2-flop chain `dcomp` → s1 → `dcomp_s`, clocked on `osc_ck` rising edge.
- `osc_ena` = `ena` & (`dcomp` | s1 | `dcomp_s` | state≠IDLE).
  - The raw `dcomp` term is required to start the stopped oscillator.
  - The sync terms keep the clock running until the synchroniser has flushed.
- FSM, updated on `osc_ck` rising edge:
  - IDLE: if `dcomp_s`=1 → FILTER, fcnt=1.
  - FILTER: if `dcomp_s`=0 → IDLE, fcnt=0 (glitch rejected, no count). Else if fcnt==FILT_DEPTH-1 → TRIP, `brout_filt`←1, `brout_cnt`←`brout_cnt`+1 unless already all-ones. Else fcnt++.
  - TRIP: if `dcomp_s`=0 → HOLD, tmr←`hold_cnt`. Else stay.
  - HOLD: if `dcomp_s`=1 → TRIP (re-trip; `brout_cnt` does NOT increment). Else if tmr==0 → IDLE, `brout_filt`←0. Else tmr--.
- `brout_filt`=1 exactly in TRIP and HOLD. `busy`=1 in FILTER, TRIP and HOLD.
- Latency, assert: `dcomp` rises (meeting setup) → `brout_filt`=1 after edge 2+FILT_DEPTH (edge 6 at default).
- Latency, deassert: `dcomp` falls → `brout_filt`=0 after edge 4+`hold_cnt`.
- `hold_cnt`=0 means a single HOLD cycle.
- `brout_cnt` saturates at 2^CNT_W-1 and never wraps.
- `ena` or `rst` asserted mid-TRIP or HOLD: `brout_filt` clears immediately and asynchronously; `osc_ena` follows `ena` combinationally.
- After `ena` returns to 1 with `dcomp` still 1, the full filter sequence restarts from IDLE.
- No X on outputs after reset; all flops are asynchronously cleared.

Test Plan:
- Reset then idle: `rst` pulse, `dcomp`=0 → `osc_ena`=0, `brout_filt`=0, `busy`=0, `brout_cnt`=0; `osc_ck` stays 0.
- Clean trip: `dcomp`=1 held → `osc_ena`=1 immediately; `brout_filt`=1 on 6th `osc_ck` rising edge; `brout_cnt`=1.
- Glitch reject: `dcomp`=1 for 3 `osc_ck` cycles then 0 → `brout_filt` never asserts, `brout_cnt`=0; FSM returns to IDLE and `osc_ena` drops to 0 after the sync flush.
- Hold-off: in TRIP with `hold_cnt`=10, `dcomp`→0 → `brout_filt` falls on edge 14 after the fall, then `osc_ena`=0. Repeat with `hold_cnt`=0 → falls on edge 4.
- Re-trip in HOLD: `hold_cnt`=20, `dcomp` returns to 1 at HOLD cycle 5 → back to TRIP; `brout_filt` stays 1 throughout; `brout_cnt` is unchanged.
- Enable and saturation:
  - `ena`=0 mid-HOLD → `brout_filt`=0 and `osc_ena`=0 asynchronously; `brout_cnt` is retained.
  - Force 260 trips with CNT_W=8 → `brout_cnt`=255.

Source files
------------

// File: rtl/brownout_ctrl_if.sv
// Comparator, hold-off and status signals between the brownout macro and its controller.
// The master side owns dcomp/hold_cnt; the controller (slave) returns enable and status.
`timescale 1ps/1ps
interface brownout_ctrl_if #(
  parameter int TMR_W = 8,
  parameter int CNT_W = 8
);
  logic             dcomp;
  logic [TMR_W-1:0] hold_cnt;
  logic             osc_ena;
  logic             brout_filt;
  logic             busy;
  logic [CNT_W-1:0] brout_cnt;

  modport master (
    output dcomp,
    output hold_cnt,
    input  osc_ena,
    input  brout_filt,
    input  busy,
    input  brout_cnt
  );

  modport slave (
    input  dcomp,
    input  hold_cnt,
    output osc_ena,
    output brout_filt,
    output busy,
    output brout_cnt
  );
endinterface

// File: rtl/brownout_ctrl.sv
// Brownout controller clocked by the on-demand RC oscillator: synchronises and filters the
// comparator, flags brownout with a programmable hold-off, then stops the oscillator when idle.
`timescale 1ps/1ps
module brownout_ctrl #(
  parameter int FILT_DEPTH = 4,   // legal range 2..15
  parameter int TMR_W      = 8,
  parameter int CNT_W      = 8
) (
  input  logic            osc_ck,
  input  logic            rst,
  input  logic            ena,
  brownout_ctrl_if.slave  bus
);

  localparam int                FCNT_W    = 4;
  localparam logic [FCNT_W-1:0] FILT_LAST = FCNT_W'(FILT_DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILTER = 2'd1,
    TRIP   = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t             state_reg, state_next;
  logic [FCNT_W-1:0]  fcnt_reg, fcnt_next;
  logic [TMR_W-1:0]   tmr_reg, tmr_next;
  logic [1:0]         sync_reg;
  logic               brout_filt_reg, brout_filt_next;
  logic               busy_reg, busy_next;
  logic [CNT_W-1:0]   cnt_reg;
  logic               trip_evt;
  logic               dcomp_s;
  logic               clr;

  // Dropping ena clears everything but the trip counter without needing a clock edge.
  assign clr     = rst | ~ena;
  assign dcomp_s = sync_reg[1];

  always_ff @(posedge osc_ck or posedge clr) begin
    if (clr) begin
      sync_reg <= 2'b00;
    end else begin
      sync_reg <= {sync_reg[0], bus.dcomp};
    end
  end

  always_ff @(posedge osc_ck or posedge clr) begin
    if (clr) begin
      state_reg      <= IDLE;
      fcnt_reg       <= '0;
      tmr_reg        <= '0;
      brout_filt_reg <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      fcnt_reg       <= fcnt_next;
      tmr_reg        <= tmr_next;
      brout_filt_reg <= brout_filt_next;
      busy_reg       <= busy_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    fcnt_next  = fcnt_reg;
    tmr_next   = tmr_reg;
    trip_evt   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (dcomp_s) begin
          state_next = FILTER;
          fcnt_next  = FCNT_W'(1);
        end
      end
      FILTER: begin
        if (!dcomp_s) begin
          state_next = IDLE;
          fcnt_next  = '0;
        end else if (fcnt_reg == FILT_LAST) begin
          state_next = TRIP;
          fcnt_next  = '0;
          trip_evt   = 1'b1;
        end else begin
          fcnt_next = fcnt_reg + FCNT_W'(1);
        end
      end
      TRIP: begin
        if (!dcomp_s) begin
          state_next = HOLD;
          tmr_next   = bus.hold_cnt;
        end
      end
      HOLD: begin
        // A renewed under-voltage wins over timer expiry and is not counted as a new trip.
        if (dcomp_s) begin
          state_next = TRIP;
        end else if (tmr_reg == '0) begin
          state_next = IDLE;
        end else begin
          tmr_next = tmr_reg - TMR_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    brout_filt_next = (state_next == TRIP) || (state_next == HOLD);
    busy_next       = (state_next != IDLE);
  end

  // Trip count survives ena toggling; only rst clears it.
  always_ff @(posedge osc_ck or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (trip_evt && (cnt_reg != {CNT_W{1'b1}})) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  // Raw dcomp starts the stopped oscillator; sync terms keep it running until flushed.
  assign bus.osc_ena    = ena & (bus.dcomp | sync_reg[0] | sync_reg[1] | (state_reg != IDLE));
  assign bus.brout_filt = brout_filt_reg;
  assign bus.busy       = busy_reg;
  assign bus.brout_cnt  = cnt_reg;

endmodule
